// File: rtl/cart_mux_scan_sched.sv
// Scan sequencer for the cartridge A0-A7 / A8-A15 / control input buffers.
// Define CART_MUX_BBM_EN for a one-cycle all-off gap between groups.
module cart_mux_scan_sched #(
   parameter int GROUPS     = 3,
   parameter int CNT_W      = 4,
   parameter int DEF_SETTLE = 2,
   parameter int DEF_HOLD   = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [CNT_W-1:0]  CFG_SETTLE,
   input  logic [CNT_W-1:0]  CFG_HOLD,
   input  logic              CFG_VALID,
   output logic              CFG_READY,
   input  logic [GROUPS-1:0] GROUP_MASK,
   input  logic              HALT_REQ,
   output logic              HALT_ACK,
   output logic [GROUPS-1:0] MUX_CS_n,
   output logic [GROUPS-1:0] SAMPLE_EN,
   output logic              FRAME_DONE,
   output logic [1:0]        CUR_GROUP
);

`ifdef CART_MUX_BBM_EN
   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, GAP, HALTED} state_t;
`else
   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, HALTED} state_t;
`endif

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t            state_q, state_d;
   logic [1:0]        grp_q, grp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  act_s_q, act_s_d, act_h_q, act_h_d;
   logic [CNT_W-1:0]  pend_s_q, pend_s_d, pend_h_q, pend_h_d;
   logic              rdy_q, rdy_d;
   logic              fd_q, fd_d;
   logic              ack_q;
   logic [GROUPS-1:0] cs_q, cs_d, se_q, se_d;
   logic [1:0]        cur_q;
   logic [2:0]        nx;
   logic [1:0]        lo;
   logic              apply, load;
   logic [CNT_W-1:0]  ld_s;
`ifdef CART_MUX_BBM_EN
   logic [1:0]        ngrp_q, ngrp_d;
   logic              wrap_q, wrap_d;
`endif

   function automatic logic [1:0] lowest(input logic [GROUPS-1:0] m);
      logic [1:0] r;
      r = '0;
      for (int i = GROUPS - 1; i >= 0; i--)
         if (m[i]) r = i[1:0];
      return r;
   endfunction

   // {wrap, index}: next set bit above g, else wrap to the lowest set bit
   function automatic logic [2:0] pick(input logic [GROUPS-1:0] m,
                                       input logic [1:0] g);
      logic [2:0] r;
      r = {1'b1, lowest(m)};
      for (int i = GROUPS - 1; i >= 0; i--)
         if (m[i] && (i > int'(g))) r = {1'b0, i[1:0]};
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      grp_d    = grp_q;
      cnt_d    = cnt_q;
      act_s_d  = act_s_q;
      act_h_d  = act_h_q;
      pend_s_d = pend_s_q;
      pend_h_d = pend_h_q;
      rdy_d    = rdy_q;
      fd_d     = 1'b0;
      apply    = 1'b0;
      load     = 1'b0;
      cs_d     = '1;
      se_d     = '0;
      nx       = pick(GROUP_MASK, grp_q);
      lo       = lowest(GROUP_MASK);
`ifdef CART_MUX_BBM_EN
      ngrp_d   = ngrp_q;
      wrap_d   = wrap_q;
`endif
      unique case (state_q)
         IDLE: begin
            apply = 1'b1;
            if (HALT_REQ) state_d = HALTED;
            else if (|GROUP_MASK) begin
               state_d = SETTLE;
               grp_d   = lo;
               load    = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = SAMPLE;
               cnt_d   = act_h_q;
            end else cnt_d = cnt_q - ONE;
         end
         SAMPLE: begin
            if (cnt_q != '0) cnt_d = cnt_q - ONE;
            else if (HALT_REQ) state_d = HALTED;
            else if (GROUP_MASK == '0) state_d = IDLE;
            else begin
`ifdef CART_MUX_BBM_EN
               state_d = GAP;
               ngrp_d  = nx[1:0];
               wrap_d  = nx[2];
`else
               state_d = SETTLE;
               grp_d   = nx[1:0];
               load    = 1'b1;
               fd_d    = nx[2];
               apply   = nx[2];
`endif
            end
         end
`ifdef CART_MUX_BBM_EN
         GAP: begin
            if (HALT_REQ) state_d = HALTED;
            else begin
               state_d = SETTLE;
               grp_d   = ngrp_q;
               load    = 1'b1;
               fd_d    = wrap_q;
               apply   = wrap_q;
            end
         end
`endif
         HALTED: begin
            apply = 1'b1;
            if (!HALT_REQ) begin
               if (GROUP_MASK == '0) state_d = IDLE;
               else begin
                  state_d = SETTLE;
                  grp_d   = nx[1:0];
                  load    = 1'b1;
                  fd_d    = nx[2];
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // a group entered at a frame boundary already runs on the new timing
      ld_s = (apply && !rdy_q) ? pend_s_q : act_s_q;
      if (load) cnt_d = ((ld_s == '0) ? ONE : ld_s) - ONE;

      if (apply && !rdy_q) begin
         act_s_d = pend_s_q;
         act_h_d = pend_h_q;
         rdy_d   = 1'b1;
      end else if (CFG_VALID && rdy_q) begin
         pend_s_d = CFG_SETTLE;
         pend_h_d = CFG_HOLD;
         rdy_d    = 1'b0;
      end

      if (state_d == SETTLE || state_d == SAMPLE) cs_d[grp_d] = 1'b0;
      if (state_d == SAMPLE) se_d[grp_d] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         grp_q    <= '0;
         cnt_q    <= '0;
         act_s_q  <= CNT_W'(DEF_SETTLE);
         act_h_q  <= CNT_W'(DEF_HOLD);
         pend_s_q <= '0;
         pend_h_q <= '0;
         rdy_q    <= 1'b1;
         fd_q     <= 1'b0;
         ack_q    <= 1'b0;
         cs_q     <= '1;
         se_q     <= '0;
         cur_q    <= '0;
`ifdef CART_MUX_BBM_EN
         ngrp_q   <= '0;
         wrap_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         grp_q    <= grp_d;
         cnt_q    <= cnt_d;
         act_s_q  <= act_s_d;
         act_h_q  <= act_h_d;
         pend_s_q <= pend_s_d;
         pend_h_q <= pend_h_d;
         rdy_q    <= rdy_d;
         fd_q     <= fd_d;
         ack_q    <= (state_d == HALTED);
         cs_q     <= cs_d;
         se_q     <= se_d;
         cur_q    <= grp_d;
`ifdef CART_MUX_BBM_EN
         ngrp_q   <= ngrp_d;
         wrap_q   <= wrap_d;
`endif
      end
   end

   assign CFG_READY  = rdy_q;
   assign HALT_ACK   = ack_q;
   assign MUX_CS_n   = cs_q;
   assign SAMPLE_EN  = se_q;
   assign FRAME_DONE = fd_q;
   assign CUR_GROUP  = cur_q;

endmodule

// File: tb/tb_cart_mux_scan_sched.sv
// Bench for cart_mux_scan_sched: directed and random stimulus against a
// window-position reference model.
`timescale 1ns/1ps
module tb_cart_mux_scan_sched;
   localparam int G = 3;
`ifdef CART_MUX_BBM_EN
   localparam int BBM = 1;
`else
   localparam int BBM = 0;
`endif

   logic       CLK = 1'b0;
   logic       RESET, CFG_VALID, HALT_REQ;
   logic       CFG_READY, HALT_ACK, FRAME_DONE;
   logic [3:0] CFG_SETTLE, CFG_HOLD;
   logic [2:0] GROUP_MASK, MUX_CS_n, SAMPLE_EN;
   logic [1:0] CUR_GROUP;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   cart_mux_scan_sched dut (
      .CLK(CLK), .RESET(RESET),
      .CFG_SETTLE(CFG_SETTLE), .CFG_HOLD(CFG_HOLD),
      .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
      .GROUP_MASK(GROUP_MASK), .HALT_REQ(HALT_REQ), .HALT_ACK(HALT_ACK),
      .MUX_CS_n(MUX_CS_n), .SAMPLE_EN(SAMPLE_EN),
      .FRAME_DONE(FRAME_DONE), .CUR_GROUP(CUR_GROUP)
   );

   always #5 CLK = ~CLK;

   // Model: a group is one window of s_eff+h+1 cycles, indexed by m_pos.
   typedef enum int {M_IDLE, M_WIN, M_GAP, M_HALT} mmode_t;
   mmode_t m_mode;
   int m_g, m_pos, m_se, m_h, m_as, m_ah, m_ps, m_ph, m_ng;
   bit m_rdy, m_fd, m_wrap;

   function automatic int lowest_set(input logic [2:0] m);
      int r;
      r = 0;
      for (int i = G - 1; i >= 0; i--) if (m[i]) r = i;
      return r;
   endfunction

   task automatic nxt(input logic [2:0] m, input int g,
                      output int n, output bit w);
      n = -1;
      for (int i = g + 1; i < G; i++) if (m[i] && n < 0) n = i;
      w = (n < 0);
      if (w) n = lowest_set(m);
   endtask

   task automatic m_reset();
      m_mode = M_IDLE; m_g = 0; m_pos = 0; m_se = 2; m_h = 1;
      m_as = 2; m_ah = 1; m_ps = 0; m_ph = 0; m_ng = 0;
      m_rdy = 1; m_fd = 0; m_wrap = 0;
   endtask

   task automatic m_apply();
      if (!m_rdy) begin
         m_as = m_ps; m_ah = m_ph; m_rdy = 1;
      end
   endtask

   task automatic m_start(input int g);
      m_mode = M_WIN; m_g = g; m_pos = 0;
      m_se = (m_as == 0) ? 1 : m_as;
      m_h = m_ah;
   endtask

   task automatic m_step();
      bit old_rdy;
      int n;
      bit w;
      if (RESET) begin
         m_reset();
         return;
      end
      old_rdy = m_rdy;
      m_fd = 0;
      case (m_mode)
         M_IDLE: begin
            m_apply();
            if (HALT_REQ) m_mode = M_HALT;
            else if (GROUP_MASK != 0) m_start(lowest_set(GROUP_MASK));
         end
         M_WIN: begin
            if (m_pos < m_se + m_h) m_pos++;
            else if (HALT_REQ) m_mode = M_HALT;
            else if (GROUP_MASK == 0) m_mode = M_IDLE;
            else begin
               nxt(GROUP_MASK, m_g, n, w);
               if (BBM != 0) begin
                  m_mode = M_GAP; m_ng = n; m_wrap = w;
               end else begin
                  if (w) begin m_fd = 1; m_apply(); end
                  m_start(n);
               end
            end
         end
         M_GAP: begin
            if (HALT_REQ) m_mode = M_HALT;
            else begin
               if (m_wrap) begin m_fd = 1; m_apply(); end
               m_start(m_ng);
            end
         end
         default: begin
            m_apply();
            if (!HALT_REQ) begin
               if (GROUP_MASK == 0) m_mode = M_IDLE;
               else begin
                  nxt(GROUP_MASK, m_g, n, w);
                  if (w) m_fd = 1;
                  m_start(n);
               end
            end
         end
      endcase
      if (CFG_VALID && old_rdy) begin
         m_ps = int'(CFG_SETTLE); m_ph = int'(CFG_HOLD); m_rdy = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [2:0] ecs, ese;
      ecs = 3'b111;
      ese = 3'b000;
      if (m_mode == M_WIN) begin
         ecs[m_g] = 1'b0;
         if (m_pos >= m_se) ese[m_g] = 1'b1;
      end
      chk("cs_n", MUX_CS_n, ecs);
      chk("sample_en", SAMPLE_EN, ese);
      chk("halt_ack", HALT_ACK, m_mode == M_HALT);
      chk("frame_done", FRAME_DONE, m_fd);
      chk("cfg_ready", CFG_READY, m_rdy);
      chk("cur_group", CUR_GROUP, m_g);
      chk("cs_onehot", $countones(~MUX_CS_n) <= 1, 1);
      chk("se_needs_cs", (SAMPLE_EN & MUX_CS_n) == 3'b000, 1);
   endtask

   task automatic tick();
      m_step();
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic measure_period(input string tag, input int exp);
      int c;
      bit got;
      got = 0;
      for (int i = 0; i < 80 && !got; i++) begin
         tick();
         if (FRAME_DONE === 1'b1) got = 1;
      end
      c = 0;
      if (got) begin
         got = 0;
         while (c < 80 && !got) begin
            tick();
            c++;
            if (FRAME_DONE === 1'b1) got = 1;
         end
      end
      chk(tag, got ? c : 0, exp);
   endtask

   initial begin
      int k;
      RESET = 1; CFG_VALID = 0; CFG_SETTLE = 0; CFG_HOLD = 0;
      GROUP_MASK = 3'b000; HALT_REQ = 0;
      m_reset();
      tick(); tick();
      RESET = 0;
      tick();

      GROUP_MASK = 3'b111;
      run(6);
      measure_period("frame_default", 3 * (4 + BBM));

      run(5);
      CFG_SETTLE = 4'd0; CFG_HOLD = 4'd3; CFG_VALID = 1;
      tick();
      CFG_VALID = 0;
      chk("ready_drops", CFG_READY, 0);
      measure_period("frame_cfg_0_3", 3 * (1 + 4 + BBM));

      GROUP_MASK = 3'b101;
      run(40);
      k = 0;
      while (k < 60 && !(m_mode == M_WIN && m_g == 2 && m_pos == 0)) begin
         tick(); k++;
      end
      chk("reach_grp2", k < 60, 1);
      tick();
      GROUP_MASK = 3'b000;
      run(20);
      chk("idle_cs", MUX_CS_n, 3'b111);

      GROUP_MASK = 3'b111;
      k = 0;
      while (k < 80 && !(m_mode == M_WIN && m_g == 1 && m_pos == 0)) begin
         tick(); k++;
      end
      chk("reach_grp1", k < 80, 1);
      HALT_REQ = 1;
      k = 0;
      while (k < 30 && m_mode != M_HALT) begin
         tick(); k++;
      end
      run(3);
      chk("halted_ack", HALT_ACK, 1);
      chk("halted_cs", MUX_CS_n, 3'b111);
      HALT_REQ = 0;
      tick();
      chk("ack_release", HALT_ACK, 0);
      chk("resume_grp", CUR_GROUP, 2);

      k = 0;
      while (k < 80 && !(m_mode == M_WIN && m_g == 1 && m_pos == 0)) begin
         tick(); k++;
      end
      CFG_SETTLE = 4'd5; CFG_HOLD = 4'd5; CFG_VALID = 1;
      tick();
      CFG_VALID = 0;
      k = 0;
      while (k < 30 && !(m_mode == M_WIN && m_g == 1 && m_pos >= m_se)) begin
         tick(); k++;
      end
      chk("reach_grp1_sample", k < 30, 1);
      RESET = 1;
      tick();
      RESET = 0;
      chk("rst_cs", MUX_CS_n, 3'b111);
      chk("rst_se", SAMPLE_EN, 3'b000);
      chk("rst_ready", CFG_READY, 1);
      measure_period("frame_after_reset", 3 * (4 + BBM));

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) GROUP_MASK = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 29) == 0) HALT_REQ = ~HALT_REQ;
         CFG_VALID  = ($urandom_range(0, 15) == 0);
         CFG_SETTLE = 4'($urandom_range(0, 3));
         CFG_HOLD   = 4'($urandom_range(0, 3));
         RESET      = ($urandom_range(0, 299) == 0);
         tick();
      end
      RESET = 0; HALT_REQ = 0; CFG_VALID = 0;
      run(5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
